// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter_pkg
// Brief    : Shared constants and types for the register-file writeback path.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_wb_arbiter_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;
    localparam int WB_DWIDTH = 32;

    typedef enum logic [0:0] {
        GNT_ALU = 1'b0,
        GNT_LSU = 1'b1
    } grant_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [WB_DWIDTH-1:0] data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [REG_IDX_W-1:0] idx);
        return NUM_REGS'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter_if
// Brief    : Issue, hazard lookup, writeback request and register-file bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int DWIDTH = 32
);
    import regfile_wb_arbiter_pkg::*;

    logic                 issue_valid_i;
    logic [REG_IDX_W-1:0] issue_rd_i;
    logic                 flush_i;
    logic [REG_IDX_W-1:0] rs1_i;
    logic [REG_IDX_W-1:0] rs2_i;
    logic                 rs1_busy_o;
    logic                 rs2_busy_o;

    logic                 alu_valid_i;
    logic [REG_IDX_W-1:0] alu_rd_i;
    logic [DWIDTH-1:0]    alu_data_i;
    logic                 alu_ready_o;

    logic                 lsu_valid_i;
    logic [REG_IDX_W-1:0] lsu_rd_i;
    logic [DWIDTH-1:0]    lsu_data_i;
    logic                 lsu_ready_o;

    logic                 wb_en_o;
    logic [REG_IDX_W-1:0] wb_rd_o;
    logic [DWIDTH-1:0]    wb_data_o;
    logic [NUM_REGS-1:0]  pending_o;

    modport master (
        output issue_valid_i, issue_rd_i, flush_i, rs1_i, rs2_i,
        output alu_valid_i, alu_rd_i, alu_data_i,
        output lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  rs1_busy_o, rs2_busy_o, alu_ready_o, lsu_ready_o,
        input  wb_en_o, wb_rd_o, wb_data_o, pending_o
    );

    modport slave (
        input  issue_valid_i, issue_rd_i, flush_i, rs1_i, rs2_i,
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  lsu_valid_i, lsu_rd_i, lsu_data_i,
        output rs1_busy_o, rs2_busy_o, alu_ready_o, lsu_ready_o,
        output wb_en_o, wb_rd_o, wb_data_o, pending_o
    );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter_scoreboard
// Brief    : Pending-write vector with set/clear/flush and two hazard lookups.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_set_en,
    input  logic [REG_IDX_W-1:0] i_set_idx,
    input  logic                 i_clr_en,
    input  logic [REG_IDX_W-1:0] i_clr_idx,
    input  logic                 i_flush,
    input  logic [REG_IDX_W-1:0] i_rs1,
    input  logic [REG_IDX_W-1:0] i_rs2,
    output logic                 o_rs1_busy,
    output logic                 o_rs2_busy,
    output logic [NUM_REGS-1:0]  o_pending
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_pending_nxt;

    // Clear first so a same-index set (younger WAW write) wins; flush beats both.
    always_comb begin
        w_pending_nxt = r_pending;
        if (i_clr_en) begin
            w_pending_nxt = w_pending_nxt & ~idx_onehot(i_clr_idx);
        end
        if (i_flush) begin
            w_pending_nxt = '0;
        end else if (i_set_en) begin
            w_pending_nxt = w_pending_nxt | idx_onehot(i_set_idx);
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign o_rs1_busy = r_pending[i_rs1];
    assign o_rs2_busy = r_pending[i_rs2];
    assign o_pending  = r_pending;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : ALU/LSU writeback arbiter, register-file write port and RAW scoreboard.
//            Define WBARB_ROUND_ROBIN_EN for round-robin contention (default: LSU wins).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DWIDTH = 32
)(
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
);

    logic                 w_alu_ready;
    logic                 w_lsu_ready;
    logic                 w_alu_xfer;
    logic                 w_lsu_xfer;
    logic                 w_xfer;
    logic                 w_contend;
    logic                 w_wr;
    logic [REG_IDX_W-1:0] w_sel_rd;
    logic [DWIDTH-1:0]    w_sel_data;

    grant_e               r_last_grant;
    grant_e               w_last_grant_nxt;

    logic                 r_wb_en;
    logic [REG_IDX_W-1:0] r_wb_rd;
    logic [DWIDTH-1:0]    r_wb_data;

    // A side is refused only when the other side is requesting and holds priority.
`ifdef WBARB_ROUND_ROBIN_EN
    assign w_lsu_ready = ~rst & ~(bus.alu_valid_i & (r_last_grant == GNT_LSU));
    assign w_alu_ready = ~rst & ~(bus.lsu_valid_i & (r_last_grant == GNT_ALU));
`else
    assign w_lsu_ready = ~rst;
    assign w_alu_ready = ~rst & ~bus.lsu_valid_i;
`endif

    assign w_alu_xfer = bus.alu_valid_i & w_alu_ready;
    assign w_lsu_xfer = bus.lsu_valid_i & w_lsu_ready;
    assign w_xfer     = w_alu_xfer | w_lsu_xfer;
    assign w_contend  = bus.alu_valid_i & bus.lsu_valid_i;

    assign bus.alu_ready_o = w_alu_ready;
    assign bus.lsu_ready_o = w_lsu_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= GNT_ALU;
        end else begin
            r_last_grant <= w_last_grant_nxt;
        end
    end

    always_comb begin
        w_last_grant_nxt = r_last_grant;
        if (w_contend) begin
            w_last_grant_nxt = w_lsu_xfer ? GNT_LSU : GNT_ALU;
        end
    end

    always_comb begin
        w_sel_rd   = bus.alu_rd_i;
        w_sel_data = bus.alu_data_i;
        if (w_lsu_xfer) begin
            w_sel_rd   = bus.lsu_rd_i;
            w_sel_data = bus.lsu_data_i;
        end
    end

    // Writes to x0 are accepted but leave the register-file port untouched.
    assign w_wr = w_xfer & (w_sel_rd != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_en   <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else begin
            r_wb_en <= w_wr;
            if (w_wr) begin
                r_wb_rd   <= w_sel_rd;
                r_wb_data <= w_sel_data;
            end
        end
    end

    assign bus.wb_en_o   = r_wb_en;
    assign bus.wb_rd_o   = r_wb_rd;
    assign bus.wb_data_o = r_wb_data;

    regfile_wb_arbiter_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (bus.issue_valid_i & (bus.issue_rd_i != '0)),
        .i_set_idx  (bus.issue_rd_i),
        .i_clr_en   (r_wb_en),
        .i_clr_idx  (r_wb_rd),
        .i_flush    (bus.flush_i),
        .i_rs1      (bus.rs1_i),
        .i_rs2      (bus.rs2_i),
        .o_rs1_busy (bus.rs1_busy_o),
        .o_rs2_busy (bus.rs2_busy_o),
        .o_pending  (bus.pending_o)
    );

endmodule
`default_nettype wire
